// File: rtl/sd_delay_timer_pkg.sv
// sd_delay_pkg: shared state codes and mode constants for the SD delay timer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sd_delay_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/sd_delay_timer_prescaler.sv
// sd_prescaler: counts 0..limit while enabled, pulses strobe on the limit cycle, then wraps to 0.
// Latency: strobe is combinational from the count (high during the limit cycle).
// Backpressure: none; clear has priority over enable for the count, not for strobe.
// Ports: clk, rst (async, active high), clear (force count to 0), enable (advance count),
//        limit (wrap value), strobe (one-cycle pulse when count==limit while enabled).
module sd_prescaler #(
  parameter int PRESCALE_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_SIZE-1:0] limit,
  output logic                     strobe
);

  logic [PRESCALE_SIZE-1:0] cnt_q, cnt_d;

  // strobe is not gated by clear: the parent may clear on the very cycle an
  // expiry happens (periodic stop) and still needs that expiry reported.
  always_comb begin
    strobe = enable && (cnt_q == limit);
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == limit) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_delay_timer.sv
// sd_delay_timer: counts (times+1) units of (prescale+1) clocks; one-shot or periodic, abortable.
// Latency: acceptance at edge E0 -> finish/tick registered at E0+(times+1)*(prescale+1).
// Backpressure: start is a held request level; one-shot needs start low before re-arming.
// Ports: clk, rst (async, active high), start, abort, periodic, times, prescale (config
//        sampled on acceptance), finish (level), tick (one-cycle pulse per expiry), busy (in RUN).
module sd_delay_timer
  import sd_delay_pkg::*;
#(
  parameter int COUNT_SIZE    = 16,
  parameter int PRESCALE_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     periodic,
  input  logic [COUNT_SIZE-1:0]    times,
  input  logic [PRESCALE_SIZE-1:0] prescale,
  output logic                     finish,
  output logic                     tick,
  output logic                     busy
);

  state_e                   state_q, state_d;
  logic [COUNT_SIZE-1:0]    unit_q, unit_d;
  logic [COUNT_SIZE-1:0]    times_l_q, times_l_d;
  logic [PRESCALE_SIZE-1:0] prescale_l_q, prescale_l_d;
  logic                     periodic_l_q, periodic_l_d;
  logic                     finish_q, finish_d;
  logic                     tick_q, tick_d;
  logic                     psc_clear, psc_en, psc_strobe;
  logic                     expiry;

  sd_prescaler #(.PRESCALE_SIZE(PRESCALE_SIZE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (psc_clear),
    .enable (psc_en),
    .limit  (prescale_l_q),
    .strobe (psc_strobe)
  );

  always_comb begin
    state_d      = state_q;
    unit_d       = unit_q;
    times_l_d    = times_l_q;
    prescale_l_d = prescale_l_q;
    periodic_l_d = periodic_l_q;
    finish_d     = finish_q;
    tick_d       = 1'b0;
    psc_clear    = 1'b0;
    psc_en       = 1'b0;
    expiry       = 1'b0;

    case (state_q)
      S_IDLE: begin
        unit_d    = '0;
        psc_clear = 1'b1;
        if (start && !abort) begin
          times_l_d    = times;
          prescale_l_d = prescale;
          periodic_l_d = periodic;
          finish_d     = 1'b0;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        psc_en = 1'b1;
        if (abort) begin
          // Abort beats a coinciding expiry: no tick, finish dropped.
          state_d   = S_IDLE;
          finish_d  = 1'b0;
          unit_d    = '0;
          psc_clear = 1'b1;
        end else begin
          expiry = psc_strobe && (unit_q == times_l_q);
          if (psc_strobe) begin
            unit_d = expiry ? '0 : unit_q + 1'b1;
          end
          if (expiry) begin
            tick_d   = 1'b1;
            finish_d = 1'b1;
            if (periodic_l_q == MODE_ONESHOT) begin
              state_d   = S_DONE;
              unit_d    = '0;
              psc_clear = 1'b1;
            end
          end
          // Periodic runs only while start is held; an expiry on the same
          // cycle is still reported above.
          if ((periodic_l_q == MODE_PERIODIC) && !start) begin
            state_d   = S_IDLE;
            unit_d    = '0;
            psc_clear = 1'b1;
          end
        end
      end

      S_DONE: begin
        unit_d    = '0;
        psc_clear = 1'b1;
        finish_d  = 1'b1;
        if (abort) begin
          state_d  = S_IDLE;
          finish_d = 1'b0;
        end else if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        unit_d    = '0;
        psc_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      unit_q       <= '0;
      times_l_q    <= '0;
      prescale_l_q <= '0;
      periodic_l_q <= 1'b0;
      finish_q     <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_q       <= unit_d;
      times_l_q    <= times_l_d;
      prescale_l_q <= prescale_l_d;
      periodic_l_q <= periodic_l_d;
      finish_q     <= finish_d;
      tick_q       <= tick_d;
    end
  end

  assign finish = finish_q;
  assign tick   = tick_q;
  assign busy   = (state_q == S_RUN);

endmodule

// File: tb/tb_sd_delay_timer.sv
// tb_sd_delay_timer: directed tests for sd_delay_timer against an edge-count based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_delay_timer;

  localparam int CS = 4;
  localparam int PS = 8;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic          periodic = 1'b0;
  logic [CS-1:0] times    = '0;
  logic [PS-1:0] prescale = '0;
  logic          finish, tick, busy;

  int n_cmp = 0;
  int n_bad = 0;

  sd_delay_timer #(.COUNT_SIZE(CS), .PRESCALE_SIZE(PS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .periodic (periodic),
    .times    (times),
    .prescale (prescale),
    .finish   (finish),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: expiries happen at edges whose distance from the acceptance
  // edge is a positive multiple of the request length.
  typedef enum {M_IDLE, M_RUN, M_DONE} mst_e;
  mst_e m_st   = M_IDLE;
  bit   m_fin  = 1'b0;
  bit   m_tick = 1'b0;
  bit   m_per  = 1'b0;
  int   m_e0   = 0;
  int   m_len  = 1;
  int   edge_n = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st   = M_IDLE;
      m_fin  = 1'b0;
      m_tick = 1'b0;
    end else begin
      edge_n++;
      m_tick = 1'b0;
      case (m_st)
        M_IDLE: if (start && !abort) begin
          m_st  = M_RUN;
          m_e0  = edge_n;
          m_len = (int'(times) + 1) * (int'(prescale) + 1);
          m_per = periodic;
          m_fin = 1'b0;
        end
        M_RUN: if (abort) begin
          m_st  = M_IDLE;
          m_fin = 1'b0;
        end else begin
          if (((edge_n - m_e0) % m_len) == 0) begin
            m_tick = 1'b1;
            m_fin  = 1'b1;
            if (!m_per) m_st = M_DONE;
          end
          if (m_per && !start) m_st = M_IDLE;
        end
        M_DONE: if (abort) begin
          m_st  = M_IDLE;
          m_fin = 1'b0;
        end else if (!start) begin
          m_st = M_IDLE;
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_finish", int'(finish), int'(m_fin));
    chk("model_tick",   int'(tick),   int'(m_tick));
    chk("model_busy",   int'(busy),   int'(m_st == M_RUN));
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Steps until tick is seen; returns its edge number, or -1 if budget runs out.
  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (tick) begin
        at = edge_n;
        break;
      end
    end
  endtask

  int e0, at, bc, nt;
  int tk[8];

  initial begin
    step(3);
    chk("rst_finish", int'(finish), 0);
    chk("rst_tick",   int'(tick),   0);
    chk("rst_busy",   int'(busy),   0);
    rst = 1'b0;
    step(2);

    // One-shot compatibility: times=3, prescale=0 -> E0+4.
    times = 4'd3; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
    step(1); e0 = edge_n;
    chk("compat_busy_on_accept", int'(busy), 1);
    wait_tick(50, at);
    chk("compat_latency", at - e0, 4);
    chk("compat_finish", int'(finish), 1);
    step(2);
    chk("compat_done_hold", int'(finish), 1);
    chk("compat_done_tick", int'(tick), 0);
    start = 1'b0;
    step(2);
    chk("compat_idle_finish", int'(finish), 1);
    chk("compat_idle_busy", int'(busy), 0);
    start = 1'b1;
    step(1);
    chk("compat_reaccept_clear", int'(finish), 0);
    wait_tick(50, at);
    start = 1'b0;
    step(2);

    // Prescaled: times=2, prescale=4 -> 15 clocks; config changes and
    // dropping start mid-run are ignored.
    times = 4'd2; prescale = 8'd4; start = 1'b1;
    step(1); e0 = edge_n;
    bc = 0; at = -1;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      if (tick && at < 0) at = edge_n;
      if (i == 3) begin
        times = 4'd0; prescale = 8'd0; start = 1'b0;
      end
      step(1);
    end
    chk("presc_latency", at - e0, 15);
    chk("presc_busy_cycles", bc, 15);
    step(2);

    // Periodic: times=1, prescale=2 -> ticks at 6, 12, 18; drop at E0+20.
    times = 4'd1; prescale = 8'd2; periodic = 1'b1; start = 1'b1;
    step(1); e0 = edge_n;
    nt = 0;
    while (edge_n < e0 + 20) begin
      step(1);
      if (tick && nt < 8) begin
        tk[nt] = edge_n - e0;
        nt++;
      end
    end
    start = 1'b0;
    chk("per_tick_count", nt, 3);
    chk("per_tick0", tk[0], 6);
    chk("per_tick1", tk[1], 12);
    chk("per_tick2", tk[2], 18);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tick) nt++;
    end
    chk("per_no_more_ticks", nt, 0);
    chk("per_finish_kept", int'(finish), 1);
    chk("per_idle", int'(busy), 0);
    periodic = 1'b0;

    // Abort on the expiry cycle: times=5, prescale=0.
    times = 4'd5; prescale = 8'd0; start = 1'b1;
    step(1); e0 = edge_n;
    step(5);
    abort = 1'b1;
    step(1);
    chk("abort_edge", edge_n - e0, 6);
    chk("abort_no_tick", int'(tick), 0);
    chk("abort_finish", int'(finish), 0);
    chk("abort_idle", int'(busy), 0);
    start = 1'b0;

    // Abort held with start in IDLE: nothing accepted.
    step(1);
    start = 1'b1;
    step(3);
    chk("abort_blocks_start", int'(busy), 0);
    abort = 1'b0;
    start = 1'b0;
    step(2);

    // Boundary: full count range, then full count and prescale range.
    times = 4'd15; prescale = 8'd0; start = 1'b1;
    step(1); e0 = edge_n;
    wait_tick(40, at);
    chk("max_times_latency", at - e0, 16);
    start = 1'b0;
    step(2);
    times = 4'd15; prescale = 8'd255; start = 1'b1;
    step(1); e0 = edge_n;
    wait_tick(5000, at);
    chk("max_delay_latency", at - e0, 4096);
    start = 1'b0;
    step(2);

    // Async reset mid-run (periodic, finish already set), then fresh start.
    times = 4'd3; prescale = 8'd1; periodic = 1'b1; start = 1'b1;
    step(1); e0 = edge_n;
    wait_tick(20, at);
    chk("pre_rst_latency", at - e0, 8);
    step(2);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_finish", int'(finish), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_tick", int'(tick), 0);
    #2;
    rst = 1'b0;
    step(1); e0 = edge_n;
    chk("post_rst_accept", int'(busy), 1);
    wait_tick(20, at);
    chk("post_rst_latency", at - e0, 8);
    start = 1'b0;
    periodic = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_delay_timer.md
Name: sd_delay_timer

Overview:
Parametrised successor to the SD-controller delay block. It counts a programmable number of time units, each unit (PRESCALE+1) clocks long, and reports completion with a level `finish` and a one-cycle `tick`. Two modes are supported: one-shot with start/finish handshake, and periodic, which repeats while start stays high. An abort input is provided. The SD init/command sequencers use it for power-up waits (>=74 clocks), Ncr/Nwr gaps and busy-poll intervals.

Parameters:
COUNT_SIZE, 16, width of unit count `times`
PRESCALE_SIZE, 8, width of prescaler value `prescale`

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request level; held high for the whole request
abort  in  1  cancel current request, one-cycle pulse or level
periodic  in  1  mode select: 0 one-shot, 1 periodic; sampled when start is accepted
times  in  COUNT_SIZE  unit count minus one; sampled when start is accepted
prescale  in  PRESCALE_SIZE  clocks per unit minus one; sampled when start is accepted
finish  out  1  level: expiry reached since last accepted start
tick  out  1  one-cycle pulse on every expiry
busy  out  1  high while in RUN

Behaviour:
- Reset (async, immediate, also mid-run): state=IDLE, unit count=0, prescaler=0, finish=0, tick=0, busy=0. Latched config is cleared to 0.
- States: IDLE, RUN, DONE. Encoding 2 bits; the unused code goes to IDLE on the next edge.
- IDLE: unit count and prescaler are held at 0.
  - If start=1 and abort=0: latch times_l, prescale_l and periodic_l; clear finish; go to RUN.
  - finish keeps its previous value in IDLE and clears only on acceptance.
- RUN: busy=1.
  - Prescaler increments each clk. When prescaler==prescale_l it wraps to 0 and produces a unit strobe.
  - The unit count increments on each unit strobe.
  - Expiry is the cycle where the unit strobe occurs and unit count==times_l.
- Latency: if start is accepted at edge E0, expiry registers at edge E0+(times+1)*(prescale+1). On that edge finish=1 and tick=1, with tick high for exactly one cycle.
  - Example: times=0, prescale=0 gives finish one edge after acceptance.
- One-shot: on expiry go to DONE. start deasserting during RUN does not stop counting.
- DONE: finish is held at 1. When start=0, go to IDLE, and finish stays 1 there. The next request needs start low then high.
- Periodic:
  - On expiry, unit count and prescaler reset to 0. The block stays in RUN and the next period begins immediately, with no dead cycle.
  - tick pulses every (times+1)*(prescale+1) cycles. finish is set on the first expiry and stays set.
  - start=0 in any RUN cycle goes to IDLE on that edge. If expiry coincides with start=0, the tick/finish for that expiry still fire.
- Abort:
  - In RUN or DONE: go to IDLE, finish=0, tick=0.
  - Abort wins over a simultaneous expiry, so no tick occurs.
  - In IDLE: start is ignored while abort=1.
- Width rules:
  - Counters use the widths of their ports.
  - Maximum delay: 2^COUNT_SIZE * 2^PRESCALE_SIZE clocks.
  - Counters never exceed the latched limit, so no wrap-around occurs.
- Input changes on times, prescale or periodic after acceptance have no effect until the next acceptance.

Decomposition:
- Package sd_delay_pkg holds:
  - state localparams ST_IDLE=0, ST_RUN=1, ST_DONE=2
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1
- Sub-module sd_prescaler (PRESCALE_SIZE):
  - inputs: clk, rst, clear, enable, limit
  - output: strobe, a one-cycle pulse when count==limit; the counter then wraps
  - The top FSM drives clear and enable.

Test Plan:
- Compatibility: times=3, prescale=0, one-shot; start high at E0 -> finish=1 and tick pulse at E0+4. finish held until start low; then IDLE with finish still 1. A new start clears finish on the acceptance edge.
- Prescaled: times=2, prescale=4 -> tick/finish at E0+15; busy high for exactly 15 cycles. Changing times/prescale mid-run has no effect.
- Periodic: times=1, prescale=2, periodic=1 -> ticks at E0+6, E0+12, E0+18. Drop start at E0+20 -> IDLE, no further ticks, finish=1.
- Abort collision: times=5, prescale=0; abort asserted on the expiry cycle (E0+6) -> no tick, finish=0, IDLE.
- Abort vs start in IDLE: start=1 and abort=1 -> stays IDLE, busy=0.
- Async reset mid-RUN: assert rst between edges -> outputs 0 immediately. After release with start still high, a fresh acceptance gives full-length latency. Boundary check: times=2^COUNT_SIZE-1 with COUNT_SIZE=4, prescale=0 -> finish at E0+16.
